// File: rtl/image_uart_sender.sv
// Streams one frame from a frame buffer to a UART transmitter, one byte per pixel,
// in raster order, using the top 8 bits of each pixel.
module image_uart_sender #(
    parameter int unsigned BIT_DEPTH    = 8,
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned HEIGHT       = 64,
    parameter int unsigned BRAM_LATENCY = 2,
    localparam int unsigned NPIX        = WIDTH * HEIGHT,
    localparam int unsigned ADDR_W      = (NPIX > 1) ? $clog2(NPIX) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    output logic [ADDR_W-1:0]    addr_out,
    output logic                 read_en_out,
    input  logic [BIT_DEPTH-1:0] pixel_in,
    output logic [7:0]           tx_data_out,
    output logic                 tx_start_out,
    input  logic                 tx_done_in,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam int unsigned LAT_W = $clog2(BRAM_LATENCY + 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [LAT_W-1:0]  LAT_MAX   = LAT_W'(BRAM_LATENCY);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        WAIT_RD = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [7:0]        data_q, data_d;
    logic              rd_en_q, rd_en_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state logic; the latency counter is zero in READ and counts up to the capture cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lat_d   = lat_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = READ;
                    addr_d  = '0;
                    lat_d   = '0;
                end
            end
            READ, WAIT_RD: begin
                if (lat_q == LAT_MAX) begin
                    data_d  = pixel_in[BIT_DEPTH-1 -: 8];
                    lat_d   = '0;
                    state_d = SEND;
                end else begin
                    lat_d   = lat_q + LAT_W'(1);
                    state_d = WAIT_RD;
                end
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done_in) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        lat_d   = '0;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
                lat_d   = '0;
            end
        endcase

        // Outputs are registered as a decode of the next state.
        rd_en_d    = (state_d == READ);
        tx_start_d = (state_d == SEND);
        done_d     = (state_d == DONE);
        busy_d     = (state_d == READ) || (state_d == WAIT_RD) ||
                     (state_d == SEND) || (state_d == WAIT_TX);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            lat_q      <= '0;
            data_q     <= '0;
            rd_en_q    <= 1'b0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            lat_q      <= lat_d;
            data_q     <= data_d;
            rd_en_q    <= rd_en_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign addr_out     = addr_q;
    assign read_en_out  = rd_en_q;
    assign tx_data_out  = data_q;
    assign tx_start_out = tx_start_q;
    assign busy_out     = busy_q;
    assign done_out     = done_q;

endmodule

// File: doc/image_uart_sender.md
IMAGE_UART_SENDER -- requirements
Module: image_uart_sender

Interface
REQ-001 SHALL have parameter BIT_DEPTH, default 8, pixel width in bits (BIT_DEPTH >= 8).
REQ-002 SHALL have parameter WIDTH, default 64, frame width in pixels.
REQ-003 SHALL have parameter HEIGHT, default 64, frame height in pixels.
REQ-004 SHALL have parameter BRAM_LATENCY, default 2, cycles from read_en_out high to pixel_in valid.
REQ-005 SHALL have port clk_in  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start_in  input  1  one-cycle pulse requesting transmission of one frame.
REQ-008 SHALL have port addr_out  output  $clog2(WIDTH*HEIGHT)  frame-buffer read address, x + y*WIDTH.
REQ-009 SHALL have port read_en_out  output  1  frame-buffer read enable.
REQ-010 SHALL have port pixel_in  input  BIT_DEPTH  frame-buffer read data.
REQ-011 SHALL have port tx_data_out  output  8  byte to UART transmitter.
REQ-012 SHALL have port tx_start_out  output  1  one-cycle pulse launching a UART byte.
REQ-013 SHALL have port tx_done_in  input  1  one-cycle pulse from UART transmitter when byte finished.
REQ-014 SHALL have port busy_out  output  1  high from frame acceptance until done_out.
REQ-015 SHALL have port done_out  output  1  one-cycle pulse after last byte completes.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WAIT_RD, SEND, WAIT_TX, DONE.
REQ-017 IDLE + start_in: SHALL go to READ next cycle with addr_out=0, busy_out=1; start_in in any other state SHALL be ignored.
REQ-018 READ: SHALL hold read_en_out=1 for exactly one cycle at current addr_out, then enter WAIT_RD.
REQ-019 WAIT_RD: SHALL count BRAM_LATENCY cycles from the READ cycle and capture pixel_in[BIT_DEPTH-1 -: 8] into tx_data_out on the cycle exactly BRAM_LATENCY after read_en_out was high, then enter SEND.
REQ-020 SEND: SHALL assert tx_start_out for exactly one cycle with tx_data_out stable, then enter WAIT_TX.
REQ-021 tx_data_out SHALL remain stable from SEND until the next capture.
REQ-022 WAIT_TX: SHALL wait indefinitely for tx_done_in; tx_done_in coincident with tx_start_out or in IDLE/READ/WAIT_RD/DONE SHALL be ignored.
REQ-023 On tx_done_in in WAIT_TX with addr_out < WIDTH*HEIGHT-1: SHALL increment addr_out by 1 and enter READ next cycle.
REQ-024 On tx_done_in in WAIT_TX with addr_out = WIDTH*HEIGHT-1: SHALL enter DONE; addr_out SHALL NOT wrap past the last pixel.
REQ-025 DONE: SHALL assert done_out for one cycle, deassert busy_out, return to IDLE with addr_out=0.
REQ-026 Bytes SHALL be sent raster order, row 0 first, x ascending, exactly WIDTH*HEIGHT bytes per frame, no header.
REQ-027 start_in coincident with done_out SHALL be ignored; a new frame needs start_in in IDLE.
REQ-028 read_en_out SHALL be 0 in all states except READ.

Reset
REQ-029 rst_in high SHALL, next edge, force IDLE, addr_out=0, read_en_out=0, tx_start_out=0, tx_data_out=0, busy_out=0, done_out=0, latency counter=0.
REQ-030 Reset mid-frame SHALL abort without a further tx_start_out or done_out; a tx_done_in arriving after reset SHALL be ignored.
REQ-031 rst_in SHALL take priority over start_in in the same cycle.

Verification
REQ-032 WIDTH=2,HEIGHT=2, BRAM model holds 0x11,0x22,0x33,0x44, UART model returns tx_done_in 10 cycles after tx_start_out; start_in pulse -> tx_data_out sequence 0x11,0x22,0x33,0x44, four tx_start_out pulses, one done_out, busy_out high throughout.
REQ-033 Latency check: start_in at cycle 0 -> read_en_out high cycle 1 addr 0, tx_start_out high cycle 1+BRAM_LATENCY+1 with BRAM_LATENCY=2 (cycle 4).
REQ-034 BIT_DEPTH=10, pixel 0x3FC -> tx_data_out=0xFF; pixel 0x004 -> 0x01.
REQ-035 start_in pulsed while busy and tx_done_in pulsed in IDLE -> no extra reads, no tx_start_out, byte count still WIDTH*HEIGHT.
REQ-036 rst_in asserted in WAIT_TX of pixel 2 -> all outputs 0 next cycle, no done_out; new start_in -> full frame from addr 0 correct.
REQ-037 Default 64x64 frame with random data -> 4096 bytes match BRAM contents in order, addr_out peaks at 4095, done_out once.
